// File: rtl/demux_pkg.sv
// demux_pkg: lane, mode and slot-state encodings shared by the demux files
package demux_pkg;
  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_PING = 1'b1;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
endpackage

// File: rtl/demux_1_to_2_reg_if.sv
// demux_1_to_2_reg_if: source and two-lane sink bundle of the registered demux
interface demux_1_to_2_reg_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             mode;
  logic             select;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;
  modport slave (
    input  mode, select, in_data, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );
  modport master (
    output mode, select, in_data, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );
endinterface

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-word output register with EMPTY/FULL state and delivery counter
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);
  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fire;
  always_comb begin
    fire    = (state_q == FULL) && ready;
    state_d = load ? FULL : fire ? EMPTY : state_q;
    data_d  = load ? din : data_q;
    count_d = fire ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign count = count_q;
endmodule

// File: rtl/demux_1_to_2_reg.sv
// demux_1_to_2_reg: steers a valid/ready word stream to lane A or B by select or ping-pong
module demux_1_to_2_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               reset,
  demux_1_to_2_reg_if.slave bus
);
  logic turn_q, turn_d;
  logic target, tgt_full, tgt_ready, in_ready, accept, load_a, load_b;
  // in_ready looks only at the target lane, so a stalled idle lane never blocks the other
  always_comb begin
    target    = (bus.mode == MODE_PING) ? turn_q : bus.select;
    tgt_full  = (target == LANE_B) ? bus.b_valid : bus.a_valid;
    tgt_ready = (target == LANE_B) ? bus.b_ready : bus.a_ready;
    in_ready  = !reset && (!tgt_full || tgt_ready);
    accept    = bus.in_valid && in_ready;
    load_a    = accept && (target == LANE_A);
    load_b    = accept && (target == LANE_B);
    turn_d    = (accept && bus.mode == MODE_PING) ? ~turn_q : turn_q;
  end
  always_ff @(posedge clk) begin
    if (reset) turn_q <= 1'b0;
    else turn_q <= turn_d;
  end
  assign bus.in_ready = in_ready;
  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
    .clk  (clk),
    .reset(reset),
    .load (load_a),
    .din  (bus.in_data),
    .ready(bus.a_ready),
    .valid(bus.a_valid),
    .data (bus.a_data),
    .count(bus.a_count)
  );
  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
    .clk  (clk),
    .reset(reset),
    .load (load_b),
    .din  (bus.in_data),
    .ready(bus.b_ready),
    .valid(bus.b_valid),
    .data (bus.b_data),
    .count(bus.b_count)
  );
endmodule

// File: tb/tb_demux_1_to_2_reg.sv
// tb_demux_1_to_2_reg: directed stimulus with per-lane scoreboard queues and a slot-occupancy model
module tb_demux_1_to_2_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic full_a = 1'b0, full_b = 1'b0, turn_m = 1'b0;
  logic [7:0] ca = '0, cb = '0;
  demux_1_to_2_reg_if #(.WIDTH(4), .CNT_W(8)) ifc ();
  demux_1_to_2_reg #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Checks one cycle at the negedge, then advances the model across the next rising edge
  task automatic mon();
    logic tgt, rdy, acc, fa, fb;
    if (reset) begin
      chk("in_ready_in_reset", {31'd0, ifc.in_ready}, 32'd0);
      qa.delete();
      qb.delete();
      full_a = 1'b0;
      full_b = 1'b0;
      turn_m = 1'b0;
      ca = '0;
      cb = '0;
      return;
    end
    chk("a_valid", {31'd0, ifc.a_valid}, {31'd0, full_a});
    chk("b_valid", {31'd0, ifc.b_valid}, {31'd0, full_b});
    chk("a_count", {24'd0, ifc.a_count}, {24'd0, ca});
    chk("b_count", {24'd0, ifc.b_count}, {24'd0, cb});
    fa = full_a & ifc.a_ready;
    fb = full_b & ifc.b_ready;
    if (fa && qa.size() > 0) chk("a_data", {28'd0, ifc.a_data}, {28'd0, qa.pop_front()});
    if (fb && qb.size() > 0) chk("b_data", {28'd0, ifc.b_data}, {28'd0, qb.pop_front()});
    tgt = ifc.mode ? turn_m : ifc.select;
    rdy = tgt ? (!full_b | ifc.b_ready) : (!full_a | ifc.a_ready);
    chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, rdy});
    acc = ifc.in_valid & rdy;
    full_a = (acc & !tgt) ? 1'b1 : fa ? 1'b0 : full_a;
    full_b = (acc & tgt) ? 1'b1 : fb ? 1'b0 : full_b;
    if (acc & !tgt) qa.push_back(ifc.in_data);
    if (acc & tgt) qb.push_back(ifc.in_data);
    if (fa) ca = ca + 8'd1;
    if (fb) cb = cb + 8'd1;
    if (acc & ifc.mode) turn_m = ~turn_m;
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic sel, input logic [3:0] d);
    ifc.select = sel;
    ifc.in_data = d;
    ifc.in_valid = 1'b1;
    tick();
  endtask
  initial begin
    ifc.mode = 1'b0;
    ifc.select = 1'b0;
    ifc.in_data = '0;
    ifc.in_valid = 1'b0;
    ifc.a_ready = 1'b1;
    ifc.b_ready = 1'b1;
    tick();
    tick();
    chk("rst_a_valid", {31'd0, ifc.a_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, ifc.b_valid}, 32'd0);
    chk("rst_a_data", {28'd0, ifc.a_data}, 32'd0);
    chk("rst_b_data", {28'd0, ifc.b_data}, 32'd0);
    chk("rst_counts", {16'd0, ifc.a_count, ifc.b_count}, 32'd0);
    reset = 1'b0;
    // select-steered back-to-back words on lane A
    send(1'b0, 4'h5);
    chk("t1_a_first", {28'd0, ifc.a_data}, 32'h5);
    send(1'b0, 4'hA);
    chk("t1_a_second", {28'd0, ifc.a_data}, 32'hA);
    ifc.in_valid = 1'b0;
    tick();
    chk("t1_a_count", {24'd0, ifc.a_count}, 32'd2);
    chk("t1_b_valid", {31'd0, ifc.b_valid}, 32'd0);
    // ping-pong alternation
    ifc.mode = 1'b1;
    for (int i = 1; i <= 4; i++) send(1'b0, 4'(i));
    ifc.in_valid = 1'b0;
    tick();
    chk("t2_a_count", {24'd0, ifc.a_count}, 32'd4);
    chk("t2_b_count", {24'd0, ifc.b_count}, 32'd2);
    // lane A stalled: input stalls behind it, then pass-through reload
    ifc.mode = 1'b0;
    ifc.a_ready = 1'b0;
    send(1'b0, 4'h7);
    ifc.in_data = 4'h8;
    #1;
    chk("t3_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    tick();
    tick();
    chk("t3_a_hold", {28'd0, ifc.a_data}, 32'h7);
    ifc.a_ready = 1'b1;
    #1;
    chk("t3_in_ready_high", {31'd0, ifc.in_ready}, 32'd1);
    tick();
    chk("t3_reload_valid", {31'd0, ifc.a_valid}, 32'd1);
    chk("t3_reload_data", {28'd0, ifc.a_data}, 32'h8);
    ifc.in_valid = 1'b0;
    tick();
    // A full and stalled, word for B still flows
    ifc.a_ready = 1'b0;
    send(1'b0, 4'h9);
    ifc.select = 1'b1;
    ifc.in_data = 4'hC;
    #1;
    chk("t4_in_ready_b", {31'd0, ifc.in_ready}, 32'd1);
    tick();
    ifc.in_valid = 1'b0;
    chk("t4_b_data", {28'd0, ifc.b_data}, 32'hC);
    tick();
    chk("t4_a_untouched", {27'd0, ifc.a_valid, ifc.a_data}, 32'h19);
    ifc.a_ready = 1'b1;
    tick();
    chk("t4_a_count", {24'd0, ifc.a_count}, 32'd7);
    // lane A counter wrap
    for (int i = 0; i < 248; i++) send(1'b0, 4'(i));
    ifc.in_valid = 1'b0;
    tick();
    chk("t5_a_count_ff", {24'd0, ifc.a_count}, 32'hFF);
    send(1'b0, 4'h1);
    ifc.in_valid = 1'b0;
    tick();
    chk("t5_a_count_wrap", {24'd0, ifc.a_count}, 32'd0);
    // reset with both slots full
    ifc.a_ready = 1'b0;
    ifc.b_ready = 1'b0;
    send(1'b0, 4'h3);
    send(1'b1, 4'h6);
    ifc.in_valid = 1'b0;
    chk("t6_both_full", {30'd0, ifc.a_valid, ifc.b_valid}, 32'd3);
    reset = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_data = 4'hF;
    #1;
    chk("t6_in_ready_rst", {31'd0, ifc.in_ready}, 32'd0);
    tick();
    chk("t6_valids", {30'd0, ifc.a_valid, ifc.b_valid}, 32'd0);
    chk("t6_datas", {24'd0, ifc.a_data, ifc.b_data}, 32'd0);
    chk("t6_counts", {16'd0, ifc.a_count, ifc.b_count}, 32'd0);
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.a_ready = 1'b1;
    ifc.b_ready = 1'b1;
    tick();
    ifc.mode = 1'b1;
    send(1'b1, 4'h2);
    ifc.in_valid = 1'b0;
    chk("t6_turn_reset_a", {27'd0, ifc.a_valid, ifc.a_data}, 32'h12);
    tick();
    chk("t6_post_counts", {16'd0, ifc.a_count, ifc.b_count}, 32'h0100);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
